// File: rtl/mem_cycle_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_cycle_pkg                                                    |
// | State encodings and index helpers for the memory cycle control.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_cycle_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } run_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Channel index arithmetic modulo n, without a divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_cycle_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_cycle_ctrl_if                                                |
// | Control, requester and memory-strobe bundle for mem_cycle_ctrl.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_cycle_ctrl_if #(
  parameter int N_CH   = 2,
  parameter int WAIT_W = 4
);
  logic              i_strt;
  logic              i_stop;
  logic              i_step;
  logic [N_CH-1:0]   i_req_rd;
  logic [N_CH-1:0]   i_req_wr;
  logic              i_done;
  logic [WAIT_W-1:0] i_cfg_wait;
  logic              o_enable;
  logic              o_r;
  logic              o_w;
  logic [N_CH-1:0]   o_gnt;
  logic              o_busy;
  logic              o_timeout_err;

  modport master (
    output i_strt, i_stop, i_step, i_req_rd, i_req_wr, i_done, i_cfg_wait,
    input  o_enable, o_r, o_w, o_gnt, o_busy, o_timeout_err
  );

  modport slave (
    input  i_strt, i_stop, i_step, i_req_rd, i_req_wr, i_done, i_cfg_wait,
    output o_enable, o_r, o_w, o_gnt, o_busy, o_timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_cycle_ctrl_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter                                                       |
// | Round-robin pick: first requester at or after i_ptr, wrapping.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter
  import mem_cycle_pkg::*;
#(
  parameter  int N_CH  = 2,
  localparam int IDX_W = idx_w(N_CH)
) (
  input  wire logic [N_CH-1:0]  i_req,
  input  wire logic [IDX_W-1:0] i_ptr,
  output logic                  o_valid,
  output logic [N_CH-1:0]       o_gnt,
  output logic [IDX_W-1:0]      o_idx
);

  int w_k;

  always_comb begin
    o_valid = 1'b0;
    o_gnt   = '0;
    o_idx   = '0;
    w_k     = 0;
    for (int i = 0; i < N_CH; i++) begin
      w_k = wrap_add(int'(i_ptr), i, N_CH);
      if (!o_valid && i_req[w_k]) begin
        o_valid    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = IDX_W'(w_k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_cycle_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_cycle_ctrl                                                   |
// | CPU run/stop/step control and arbitrated memory bus sequencer.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_cycle_ctrl
  import mem_cycle_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int WAIT_W = 4,
  parameter int TO_CYC = 64
) (
  input wire logic        clk,
  input wire logic        rst_n,
  mem_cycle_ctrl_if.slave bus
);

  localparam int IDX_W = idx_w(N_CH);
  localparam int TC_W  = $clog2(TO_CYC);

  run_state_t        r_run, w_run_nxt;
  bus_state_t        r_bus, w_bus_nxt;
  logic [WAIT_W-1:0] r_wcnt;
  logic [TC_W-1:0]   r_tcnt;
  logic              r_stop_pend;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_win;

  logic [N_CH-1:0]   w_req;
  logic [N_CH-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]  w_arb_idx;
  logic              w_arb_valid;
  logic              w_stop_eff;
  logic              w_start;
  logic              w_done_ok;
  logic              w_tmo;

  assign w_req = bus.i_req_rd | bus.i_req_wr;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_valid (w_arb_valid),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx)
  );

  // A pending stop blocks new accesses so RUN can drain to HALT.
  assign w_stop_eff = bus.i_stop | r_stop_pend;
  assign w_start    = (r_bus == IDLE) && (r_run != HALT) && w_arb_valid &&
                      !((r_run == RUN) && w_stop_eff);
  assign w_done_ok  = bus.i_done && (r_wcnt == '0);
  assign w_tmo      = (r_tcnt == TC_W'(TO_CYC - 1));

  always_comb begin
    w_bus_nxt = r_bus;
    case (r_bus)
      IDLE:    if (w_start) w_bus_nxt = ACCESS;
      ACCESS:  if (w_done_ok || w_tmo) w_bus_nxt = DONE;
      DONE:    w_bus_nxt = IDLE;
      default: w_bus_nxt = IDLE;
    endcase

    w_run_nxt = r_run;
    case (r_run)
      HALT: begin
        if (bus.i_strt && !bus.i_stop) w_run_nxt = RUN;
        else if (bus.i_step)           w_run_nxt = STEP;
      end
      RUN:     if (w_stop_eff && (r_bus == IDLE)) w_run_nxt = HALT;
      STEP:    if (((r_bus == IDLE) && !w_start) || (r_bus == DONE)) w_run_nxt = HALT;
      default: w_run_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run             <= HALT;
      r_bus             <= IDLE;
      r_wcnt            <= '0;
      r_tcnt            <= '0;
      r_stop_pend       <= 1'b0;
      r_ptr             <= '0;
      r_win             <= '0;
      bus.o_enable      <= 1'b0;
      bus.o_r           <= 1'b0;
      bus.o_w           <= 1'b0;
      bus.o_gnt         <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_timeout_err <= 1'b0;
    end else begin
      r_run        <= w_run_nxt;
      r_bus        <= w_bus_nxt;
      r_stop_pend  <= (r_run == RUN) && w_stop_eff && (r_bus != IDLE);
      bus.o_enable <= (w_run_nxt != HALT) && (w_bus_nxt != ACCESS);
      bus.o_busy   <= (w_bus_nxt != IDLE);
      case (r_bus)
        IDLE: begin
          if (w_start) begin
            r_win     <= w_arb_idx;
            bus.o_gnt <= w_arb_gnt;
            // Write has priority when a channel asserts both requests.
            bus.o_w   <= |(bus.i_req_wr & w_arb_gnt);
            bus.o_r   <= (|(bus.i_req_rd & w_arb_gnt)) && !(|(bus.i_req_wr & w_arb_gnt));
            r_wcnt    <= bus.i_cfg_wait;
            r_tcnt    <= '0;
          end
        end
        ACCESS: begin
          if (w_done_ok || w_tmo) begin
            bus.o_r <= 1'b0;
            bus.o_w <= 1'b0;
            if (w_tmo && !w_done_ok) bus.o_timeout_err <= 1'b1;
          end else begin
            if (r_wcnt != '0) r_wcnt <= r_wcnt - 1'b1;
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        DONE: begin
          bus.o_gnt <= '0;
          r_ptr     <= IDX_W'(wrap_add(int'(r_win), 1, N_CH));
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
